// File: rtl/fifo_bus_arbiter_pkg.sv
// Shared definitions for the FTDI FIFO bus arbiter: FSM encoding, transfer
// direction and the default strobe/turnaround timing.
package fifo_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_STROBE,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    SIWU,
    TURN
  } state_t;

  typedef enum logic {
    DIR_RX = 1'b0,
    DIR_TX = 1'b1
  } dir_t;

  localparam int DEF_RD_PULSE    = 3;
  localparam int DEF_WR_PULSE    = 3;
  localparam int DEF_TURN_CYCLES = 2;
  localparam int DEF_BURST_MAX   = 8;
  localparam int DEF_SIWU_CYCLES = 4;

  localparam int TIMER_W = 8;

  // A timer loaded with N-1 reports done in the N-th cycle of the interval.
  function automatic logic [TIMER_W-1:0] interval_load(input int cycles);
    return (cycles > 1) ? TIMER_W'(cycles - 1) : '0;
  endfunction

endpackage

// File: rtl/fifo_bus_arbiter_if.sv
// Bundle of FTDI-side bus signals and the byte-stream handshakes of the
// arbiter; master is the arbiter's view, slave is the surrounding logic.
interface fifo_bus_if;
  logic       iFIFO_RXF_n;
  logic       iFIFO_TXE_n;
  logic [7:0] iFIFO_DATA;
  logic       oFIFO_RD_n;
  logic       oFIFO_WR_n;
  logic       oFIFO_OE_n;
  logic [7:0] oFIFO_DATA;
  logic       oSIWU_n;
  logic [7:0] oRX_DATA;
  logic       oRX_VALID;
  logic       iRX_READY;
  logic [7:0] iTX_DATA;
  logic       iTX_VALID;
  logic       oTX_READY;
  logic       iFLUSH;
  logic       oBUSY;

  modport master (
    input  iFIFO_RXF_n, iFIFO_TXE_n, iFIFO_DATA, iRX_READY, iTX_DATA, iTX_VALID, iFLUSH,
    output oFIFO_RD_n, oFIFO_WR_n, oFIFO_OE_n, oFIFO_DATA, oSIWU_n,
           oRX_DATA, oRX_VALID, oTX_READY, oBUSY
  );

  modport slave (
    output iFIFO_RXF_n, iFIFO_TXE_n, iFIFO_DATA, iRX_READY, iTX_DATA, iTX_VALID, iFLUSH,
    input  oFIFO_RD_n, oFIFO_WR_n, oFIFO_OE_n, oFIFO_DATA, oSIWU_n,
           oRX_DATA, oRX_VALID, oTX_READY, oBUSY
  );
endinterface

// File: rtl/fifo_bus_arbiter_strobe_timer.sv
// Loadable down-counter that times strobe and turnaround intervals; done is
// high while the count sits at zero.
module strobe_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/fifo_bus_arbiter.sv
// Half-duplex arbiter for an FTDI synchronous-style FIFO bus: grants reads,
// writes and send-immediate flushes, then sequences the strobes for each.
module fifo_bus_arbiter
  import fifo_bus_pkg::*;
#(
  parameter int RD_PULSE    = DEF_RD_PULSE,
  parameter int WR_PULSE    = DEF_WR_PULSE,
  parameter int TURN_CYCLES = DEF_TURN_CYCLES,
  parameter int BURST_MAX   = DEF_BURST_MAX,
  parameter int SIWU_CYCLES = DEF_SIWU_CYCLES
) (
  input  logic      clk,
  input  logic      rst,
  fifo_bus_if.master bus
);

  localparam int BW = $clog2(BURST_MAX + 1);

  state_t               state_reg, state_next;
  dir_t                 last_dir_reg;
  logic [BW-1:0]        burst_cnt_reg;
  logic [7:0]           rx_data_reg;
  logic                 rx_valid_reg;
  logic [7:0]           fifo_data_reg;
  logic                 flush_reg;
  logic                 wrote_since_siwu_reg;

  logic                 rx_req, tx_req, burst_open;
  logic                 grant_rx, grant_tx, grant_flush;
  logic                 timer_load, timer_done, rd_last;
  logic [TIMER_W-1:0]   timer_value;
  dir_t                 grant_dir;

  assign rx_req     = !bus.iFIFO_RXF_n && (!rx_valid_reg || bus.iRX_READY);
  assign tx_req     = !bus.iFIFO_TXE_n && bus.iTX_VALID;
  // A zero count means no burst is running yet, so contention goes to the
  // direction opposite the last one.
  assign burst_open = (burst_cnt_reg != '0) && (burst_cnt_reg < BW'(BURST_MAX));
  assign grant_dir  = grant_tx ? DIR_TX : DIR_RX;
  assign rd_last    = (state_reg == RD_STROBE) && timer_done;

  // A flush jumps the queue only when nothing was written since the last one;
  // otherwise queued traffic goes first and the flush waits for a quiet bus.
  always_comb begin
    grant_rx    = 1'b0;
    grant_tx    = 1'b0;
    grant_flush = 1'b0;
    if (state_reg == IDLE) begin
      if (flush_reg && !wrote_since_siwu_reg) begin
        grant_flush = 1'b1;
      end else if (rx_req && tx_req) begin
        if ((last_dir_reg == DIR_RX) == burst_open) grant_rx = 1'b1;
        else                                         grant_tx = 1'b1;
      end else if (rx_req) begin
        grant_rx = 1'b1;
      end else if (tx_req) begin
        grant_tx = 1'b1;
      end else if (flush_reg) begin
        grant_flush = 1'b1;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    timer_load  = 1'b0;
    timer_value = '0;
    case (state_reg)
      IDLE: begin
        if (grant_flush) begin
          state_next  = SIWU;
          timer_load  = 1'b1;
          timer_value = interval_load(SIWU_CYCLES);
        end else if (grant_rx) begin
          state_next  = RD_STROBE;
          timer_load  = 1'b1;
          timer_value = interval_load(RD_PULSE);
        end else if (grant_tx) begin
          state_next  = WR_SETUP;
        end
      end
      RD_STROBE, SIWU: begin
        if (timer_done) begin
          state_next  = TURN;
          timer_load  = 1'b1;
          timer_value = interval_load(TURN_CYCLES);
        end
      end
      WR_SETUP: begin
        state_next  = WR_STROBE;
        timer_load  = 1'b1;
        timer_value = interval_load(WR_PULSE);
      end
      WR_STROBE: begin
        if (timer_done) state_next = WR_HOLD;
      end
      WR_HOLD: begin
        state_next  = TURN;
        timer_load  = 1'b1;
        timer_value = interval_load(TURN_CYCLES);
      end
      TURN: begin
        if (timer_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_reg          <= '0;
      rx_valid_reg         <= 1'b0;
      fifo_data_reg        <= '0;
      flush_reg            <= 1'b0;
      wrote_since_siwu_reg <= 1'b0;
      burst_cnt_reg        <= '0;
      last_dir_reg         <= DIR_TX;
    end else begin
      // A fresh latch wins over the consumer's take in the same cycle.
      if (rd_last) begin
        rx_data_reg  <= bus.iFIFO_DATA;
        rx_valid_reg <= 1'b1;
      end else if (bus.iRX_READY) begin
        rx_valid_reg <= 1'b0;
      end

      if (grant_tx) fifo_data_reg <= bus.iTX_DATA;

      flush_reg <= bus.iFLUSH || (flush_reg && !grant_flush);

      if (grant_tx)         wrote_since_siwu_reg <= 1'b1;
      else if (grant_flush) wrote_since_siwu_reg <= 1'b0;

      if (grant_rx || grant_tx) begin
        last_dir_reg <= grant_dir;
        if (grant_dir != last_dir_reg)               burst_cnt_reg <= BW'(1);
        else if (burst_cnt_reg < BW'(BURST_MAX))     burst_cnt_reg <= burst_cnt_reg + BW'(1);
      end
    end
  end

  strobe_timer #(.W(TIMER_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (timer_load),
    .value (timer_value),
    .done  (timer_done)
  );

  assign bus.oFIFO_RD_n = (state_reg != RD_STROBE);
  assign bus.oFIFO_WR_n = (state_reg != WR_STROBE);
  assign bus.oFIFO_OE_n = !((state_reg == WR_SETUP) || (state_reg == WR_STROBE) ||
                            (state_reg == WR_HOLD));
  assign bus.oSIWU_n    = (state_reg != SIWU);
  assign bus.oFIFO_DATA = fifo_data_reg;
  assign bus.oRX_DATA   = rx_data_reg;
  assign bus.oRX_VALID  = rx_valid_reg;
  assign bus.oTX_READY  = grant_tx && !rst;
  assign bus.oBUSY      = (state_reg != IDLE);

endmodule
